uart_frame_ctrl: RTL and testbench

Frame controller sitting between the uart_rx byte receiver and the 64-bit consumer logic. It hunts the byte stream for a run of sync bytes, then collects a fixed-length payload into a wide word. It enforces an inter-byte timeout and delivers each completed frame over a valid/ready handshake. It replaces ad-hoc byte counting with a single sequenced, clock-synchronous state machine.

---
 rtl/uart_frame_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: hunts a byte stream from uart_rx for a run of sync bytes,
// gathers a fixed-length payload into a wide word, enforces an inter-byte
// timeout and presents each finished frame over a valid/ready handshake.
// Optional feature macro: UART_FRAME_CSUM_EN adds a trailing XOR checksum
// byte (CHECK state); without it err_csum is tied low.
module uart_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hAA,
  parameter int         SYNC_COUNT     = 2,
  parameter int         PAYLOAD_BYTES  = 8,
  parameter int         TIMEOUT_CYCLES = 104167
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_break,
  output logic [8*PAYLOAD_BYTES-1:0] frame_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [1:0]                 state,
  output logic [3:0]                 byte_cnt,
  output logic                       err_timeout,
  output logic                       err_overrun,
  output logic                       err_csum,
  output logic [15:0]                frame_count
);

  localparam int W  = 8 * PAYLOAD_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0]    SYNC_LAST = 4'(SYNC_COUNT - 1);
  localparam logic [3:0]    BYTE_LAST = 4'(PAYLOAD_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

`ifdef UART_FRAME_CSUM_EN
  typedef enum logic [1:0] {
    HUNT    = 2'b00,
    COLLECT = 2'b01,
    HOLD    = 2'b10,
    CHECK   = 2'b11
  } state_t;
`else
  typedef enum logic [1:0] {
    HUNT    = 2'b00,
    COLLECT = 2'b01,
    HOLD    = 2'b10
  } state_t;
`endif

  state_t        state_q, state_nxt;
  logic [3:0]    sync_cnt, sync_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [3:0]    byte_nxt;
  logic [W-1:0]  data_nxt;
  logic [W-1:0]  frame_shift;
  logic [15:0]   count_nxt;
  logic          timeout_nxt;
  logic          overrun_nxt;
  logic          hunt_byte;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]    csum, csum_nxt;
  logic          csum_err_nxt;
`endif

  // The newest byte enters at the LSB end so the first byte ends up in the MSBs;
  // truncating the concatenation also keeps the single-byte payload case legal.
  assign frame_shift = W'({frame_data, rx_data});

  // The frame is offered exactly while the FSM sits in HOLD, so an async reset drops it at once.
  assign frame_valid = (state_q == HOLD);
  assign state       = state_q;

  // Next-state and datapath decisions; break and sync-hunting rules are applied last so they override.
  always_comb begin
    state_nxt   = state_q;
    sync_nxt    = sync_cnt;
    tmo_nxt     = tmo_cnt;
    byte_nxt    = byte_cnt;
    data_nxt    = frame_data;
    count_nxt   = frame_count;
    timeout_nxt = 1'b0;
    overrun_nxt = 1'b0;
    hunt_byte   = 1'b0;
`ifdef UART_FRAME_CSUM_EN
    csum_nxt     = csum;
    csum_err_nxt = 1'b0;
`endif

    case (state_q)
      HUNT: begin
        hunt_byte = rx_valid;
      end

      COLLECT: begin
        if (rx_valid) begin
          data_nxt = frame_shift;
          byte_nxt = byte_cnt + 4'd1;
          tmo_nxt  = '0;
`ifdef UART_FRAME_CSUM_EN
          csum_nxt = csum ^ rx_data;
          if (byte_cnt == BYTE_LAST) state_nxt = CHECK;
`else
          if (byte_cnt == BYTE_LAST) state_nxt = HOLD;
`endif
        end else if (tmo_cnt == TMO_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = HUNT;
          byte_nxt    = '0;
          tmo_nxt     = '0;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end

`ifdef UART_FRAME_CSUM_EN
      CHECK: begin
        if (rx_valid) begin
          tmo_nxt = '0;
          if (rx_data == csum) begin
            state_nxt = HOLD;
          end else begin
            csum_err_nxt = 1'b1;
            state_nxt    = HUNT;
            byte_nxt     = '0;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = HUNT;
          byte_nxt    = '0;
          tmo_nxt     = '0;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
`endif

      HOLD: begin
        if (frame_ready) begin
          count_nxt = frame_count + 16'd1;
          byte_nxt  = '0;
          state_nxt = HUNT;
          hunt_byte = rx_valid;
        end else if (rx_valid) begin
          overrun_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = HUNT;
      end
    endcase

    if (hunt_byte) begin
      if (rx_data == SYNC_BYTE) begin
        if (sync_cnt == SYNC_LAST) begin
          state_nxt = COLLECT;
          sync_nxt  = '0;
          byte_nxt  = '0;
          tmo_nxt   = '0;
`ifdef UART_FRAME_CSUM_EN
          csum_nxt  = '0;
`endif
        end else begin
          sync_nxt = sync_cnt + 4'd1;
        end
      end else begin
        sync_nxt = '0;
      end
    end

    if (rx_break && (state_q != HOLD)) begin
      state_nxt   = HUNT;
      sync_nxt    = '0;
      tmo_nxt     = '0;
      byte_nxt    = '0;
      timeout_nxt = 1'b0;
`ifdef UART_FRAME_CSUM_EN
      csum_err_nxt = 1'b0;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= HUNT;
    else       state_q <= state_nxt;
  end

  // Counters, payload word and one-cycle error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_cnt    <= '0;
      tmo_cnt     <= '0;
      byte_cnt    <= '0;
      frame_data  <= '0;
      frame_count <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      sync_cnt    <= sync_nxt;
      tmo_cnt     <= tmo_nxt;
      byte_cnt    <= byte_nxt;
      frame_data  <= data_nxt;
      frame_count <= count_nxt;
      err_timeout <= timeout_nxt;
      err_overrun <= overrun_nxt;
    end
  end

`ifdef UART_FRAME_CSUM_EN
  // Running XOR of the payload and the checksum-error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum     <= '0;
      err_csum <= 1'b0;
    end else begin
      csum     <= csum_nxt;
      err_csum <= csum_err_nxt;
    end
  end
`else
  assign err_csum = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed testbench for uart_frame_ctrl; timeout shortened so the run stays small.
module tb_uart_frame_ctrl;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_break;
  logic        frame_ready;
  logic [63:0] frame_data;
  logic        frame_valid;
  logic [1:0]  state;
  logic [3:0]  byte_cnt;
  logic        err_timeout;
  logic        err_overrun;
  logic        err_csum;
  logic [15:0] frame_count;

  int checks = 0;
  int failures = 0;
  int tmo_pulses = 0;
  int ovr_pulses = 0;
  int fv_cycles = 0;
  int base;
  logic [63:0] held;

  uart_frame_ctrl #(
    .SYNC_BYTE(8'hAA),
    .SYNC_COUNT(2),
    .PAYLOAD_BYTES(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_break(rx_break),
    .frame_data(frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .state(state),
    .byte_cnt(byte_cnt),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun),
    .err_csum(err_csum),
    .frame_count(frame_count)
  );

  // 100 MHz-style free-running clock; period only matters relative to the bench.
  always #5 clk = ~clk;

  // Count pulses and valid cycles on the inactive edge.
  always @(negedge clk) begin
    if (err_timeout) tmo_pulses++;
    if (err_overrun) ovr_pulses++;
    if (frame_valid) fv_cycles++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    rx_valid = 1'b1;
    rx_data  = data;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic sendPayload(input logic [63:0] payload);
`ifdef UART_FRAME_CSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(payload[i*8 +: 8]);
`ifdef UART_FRAME_CSUM_EN
      x = x ^ payload[i*8 +: 8];
`endif
    end
`ifdef UART_FRAME_CSUM_EN
    applyStimulus(x);
`endif
  endtask

  task automatic sendFrame(input logic [63:0] payload);
    applyStimulus(8'hAA);
    applyStimulus(8'hAA);
    sendPayload(payload);
  endtask

  initial begin
    reset       = 1'b1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    rx_break    = 1'b0;
    frame_ready = 1'b0;
    idle(2);
    checkOutput("rst_state", 64'(state), 64'd0);
    checkOutput("rst_byte_cnt", 64'(byte_cnt), 64'd0);
    checkOutput("rst_frame_data", frame_data, 64'd0);
    checkOutput("rst_frame_valid", 64'(frame_valid), 64'd0);
    checkOutput("rst_frame_count", 64'(frame_count), 64'd0);
    checkOutput("rst_errs", 64'({err_timeout, err_overrun, err_csum}), 64'd0);
    reset = 1'b0;
    idle(1);

    // Basic frame with the consumer always ready.
    frame_ready = 1'b1;
    applyStimulus(8'hAA);
    applyStimulus(8'hAA);
    checkOutput("t1_collect", 64'(state), 64'd1);
    base = fv_cycles;
    sendPayload(64'h0102030405060708);
    checkOutput("t1_hold", 64'(state), 64'd2);
    checkOutput("t1_valid", 64'(frame_valid), 64'd1);
    checkOutput("t1_data", frame_data, 64'h0102030405060708);
    checkOutput("t1_byte_cnt", 64'(byte_cnt), 64'd8);
    idle(1);
    checkOutput("t1_back_hunt", 64'(state), 64'd0);
    checkOutput("t1_valid_low", 64'(frame_valid), 64'd0);
    checkOutput("t1_count", 64'(frame_count), 64'd1);
    checkOutput("t1_valid_cycles", 64'(fv_cycles - base), 64'd1);
    frame_ready = 1'b0;

    // Non-sync byte breaks a partial sync run; sync-valued payload is data.
    applyStimulus(8'hAA);
    applyStimulus(8'h55);
    applyStimulus(8'hAA);
    checkOutput("t2_sync_reset", 64'(state), 64'd0);
    applyStimulus(8'hAA);
    checkOutput("t2_collect", 64'(state), 64'd1);
    sendPayload(64'hAAAAAAAAAAAAAAAA);
    checkOutput("t2_data", frame_data, 64'hAAAAAAAAAAAAAAAA);
    checkOutput("t2_byte_cnt", 64'(byte_cnt), 64'd8);
    frame_ready = 1'b1;
    idle(1);
    frame_ready = 1'b0;
    checkOutput("t2_count", 64'(frame_count), 64'd2);

    // Inter-byte timeout fires exactly TMO idle cycles after the last byte.
    applyStimulus(8'hAA);
    applyStimulus(8'hAA);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    checkOutput("t3_byte_cnt", 64'(byte_cnt), 64'd3);
    base = tmo_pulses;
    idle(TMO - 1);
    checkOutput("t3_not_yet", 64'({state, err_timeout}), 64'({2'd1, 1'b0}));
    idle(1);
    checkOutput("t3_pulse", 64'(err_timeout), 64'd1);
    checkOutput("t3_state", 64'(state), 64'd0);
    checkOutput("t3_byte_cnt0", 64'(byte_cnt), 64'd0);
    idle(2 * TMO);
    checkOutput("t3_pulse_count", 64'(tmo_pulses - base), 64'd1);
    checkOutput("t3_hunt_waits", 64'({state, frame_valid}), 64'd0);

    // Overrun in HOLD, break ignored in HOLD, byte coincident with handshake.
    sendFrame(64'h1020304050607080);
    checkOutput("t4_hold", 64'(state), 64'd2);
    held = frame_data;
    base = ovr_pulses;
    applyStimulus(8'h11);
    checkOutput("t4_overrun", 64'(err_overrun), 64'd1);
    checkOutput("t4_still_hold", 64'(state), 64'd2);
    checkOutput("t4_data_kept", frame_data, 64'h1020304050607080);
    rx_break = 1'b1;
    idle(1);
    rx_break = 1'b0;
    checkOutput("t4_break_ignored", 64'({state, frame_valid}), 64'({2'd2, 1'b1}));
    checkOutput("t4_overrun_once", 64'(ovr_pulses - base), 64'd1);
    frame_ready = 1'b1;
    applyStimulus(8'hAA);
    frame_ready = 1'b0;
    checkOutput("t4_handshake", 64'({state, frame_valid}), 64'd0);
    checkOutput("t4_count3", 64'(frame_count), 64'd3);
    applyStimulus(8'hAA);
    checkOutput("t4_coincident_sync", 64'(state), 64'd1);
    sendPayload(64'hF0E1D2C3B4A59687);
    checkOutput("t4_data2", frame_data, 64'hF0E1D2C3B4A59687);
    frame_ready = 1'b1;
    idle(1);
    frame_ready = 1'b0;
    checkOutput("t4_count4", 64'(frame_count), 64'd4);

    // Break during COLLECT returns to HUNT silently.
    base = tmo_pulses;
    applyStimulus(8'hAA);
    applyStimulus(8'hAA);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    rx_break = 1'b1;
    idle(1);
    rx_break = 1'b0;
    checkOutput("brk_state", 64'({state, byte_cnt}), 64'd0);
    checkOutput("brk_no_err", 64'(tmo_pulses - base), 64'd0);

    // Asynchronous reset mid-frame, then a clean frame.
    applyStimulus(8'hAA);
    applyStimulus(8'hAA);
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i));
    checkOutput("t5_byte_cnt5", 64'(byte_cnt), 64'd5);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5_async_state", 64'({state, byte_cnt}), 64'd0);
    checkOutput("t5_async_data", frame_data, 64'd0);
    checkOutput("t5_async_count", 64'(frame_count), 64'd0);
    #3;
    reset = 1'b0;
    idle(1);
    frame_ready = 1'b1;
    sendFrame(64'h0011223344556677);
    checkOutput("t5_data", frame_data, 64'h0011223344556677);
    idle(1);
    frame_ready = 1'b0;
    checkOutput("t5_count", 64'(frame_count), 64'd1);

`ifdef UART_FRAME_CSUM_EN
    // Checksum good then bad.
    applyStimulus(8'hAA);
    applyStimulus(8'hAA);
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
    checkOutput("t6_check_state", 64'(state), 64'd3);
    applyStimulus(8'h08);
    checkOutput("t6_good", 64'({state, frame_valid}), 64'({2'd2, 1'b1}));
    checkOutput("t6_good_data", frame_data, 64'h0102030405060708);
    frame_ready = 1'b1;
    idle(1);
    frame_ready = 1'b0;
    checkOutput("t6_count", 64'(frame_count), 64'd2);
    applyStimulus(8'hAA);
    applyStimulus(8'hAA);
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
    applyStimulus(8'h00);
    checkOutput("t6_csum_err", 64'(err_csum), 64'd1);
    checkOutput("t6_bad_state", 64'({state, frame_valid}), 64'd0);
    idle(1);
    checkOutput("t6_csum_pulse", 64'(err_csum), 64'd0);
`else
    checkOutput("csum_tied", 64'(err_csum), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
